// File: rtl/mycpu_pkg.sv
// Shared definitions for the mul/div unit.
// Op encodings, FSM states and the default data width.
package mycpu_pkg;

    localparam int DATA_WIDTH_DEF = 32;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // True for the ops that interpret operands as two's complement.
    function automatic logic op_is_signed(input logic [2:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/mycpu_muldiv_step.sv
// One radix-2 iteration on unsigned magnitudes:
// shift-add for multiply, restoring subtract for divide.
module mycpu_muldiv_step #(
    parameter int W = 32
) (
    input  logic         is_div,
    input  logic [W-1:0] acc_hi,
    input  logic [W-1:0] acc_lo,
    input  logic [W-1:0] operand,
    output logic [W-1:0] nxt_hi,
    output logic [W-1:0] nxt_lo
);

    logic [W:0]   sum;
    logic [W:0]   shifted;
    logic [W-1:0] diff;
    logic         fits;

    // Multiply: {hi,lo} shifts right with the carry entering hi.
    // Divide: {rem,quo} shifts left, subtract when divisor fits.
    always_comb begin
        sum     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, operand} : '0);
        shifted = {acc_hi, acc_lo[W-1]};
        fits    = (shifted >= {1'b0, operand});
        diff    = shifted[W-1:0] - operand;
        if (is_div) begin
            nxt_hi = fits ? diff : shifted[W-1:0];
            nxt_lo = {acc_lo[W-2:0], fits};
        end else begin
            nxt_hi = sum[W:1];
            nxt_lo = {sum[0], acc_lo[W-1:1]};
        end
    end

endmodule

// File: rtl/mycpu_muldiv.sv
// Iterative multiply/divide unit owning the HI/LO registers.
// Signed ops run on magnitudes; the sign is applied at write-back.
module mycpu_muldiv
    import mycpu_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int SIGN_EN    = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2:0]            op,
    input  logic [DATA_WIDTH-1:0] src_a,
    input  logic [DATA_WIDTH-1:0] src_b,
    input  logic                  cancel,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  div_by_zero,
    output logic [DATA_WIDTH-1:0] hi,
    output logic [DATA_WIDTH-1:0] lo
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    state_e         state_q, state_d;
    logic [W-1:0]   acc_hi_q, acc_hi_d;
    logic [W-1:0]   acc_lo_q, acc_lo_d;
    logic [W-1:0]   opnd_q, opnd_d;
    logic [W-1:0]   a_raw_q, a_raw_d;
    logic [W-1:0]   hi_q, hi_d;
    logic [W-1:0]   lo_q, lo_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           is_div_q, is_div_d;
    logic           neg_q_q, neg_q_d;
    logic           neg_r_q, neg_r_d;
    logic           dbz_q, dbz_d;

    logic [W-1:0]   step_hi, step_lo;
    logic           sgn, a_neg, b_neg, accept;
    logic [W-1:0]   a_mag, b_mag;
    logic [2*W-1:0] prod, prod_fix;
    logic [W-1:0]   quo_fix, rem_fix;

    mycpu_muldiv_step #(
        .W (W)
    ) u_step (
        .is_div  (is_div_q),
        .acc_hi  (acc_hi_q),
        .acc_lo  (acc_lo_q),
        .operand (opnd_q),
        .nxt_hi  (step_hi),
        .nxt_lo  (step_lo)
    );

    // Operand magnitudes at issue and sign fixup at completion.
    always_comb begin
        sgn      = (SIGN_EN != 0) && op_is_signed(op);
        a_neg    = sgn && src_a[W-1];
        b_neg    = sgn && src_b[W-1];
        a_mag    = a_neg ? -src_a : src_a;
        b_mag    = b_neg ? -src_b : src_b;
        prod     = {acc_hi_q, acc_lo_q};
        prod_fix = neg_q_q ? -prod : prod;
        quo_fix  = neg_q_q ? -acc_lo_q : acc_lo_q;
        rem_fix  = neg_r_q ? -acc_hi_q : acc_hi_q;
    end

    // Next-state, datapath and handshake logic.
    always_comb begin
        state_d  = state_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        opnd_d   = opnd_q;
        a_raw_d  = a_raw_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        neg_q_d  = neg_q_q;
        neg_r_d  = neg_r_q;
        dbz_d    = dbz_q;
        in_ready = (state_q == ST_IDLE) && !cancel && !reset;
        accept   = in_valid && in_ready;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    case (op)
                        OP_MULT, OP_MULTU: begin
                            state_d  = ST_CALC;
                            is_div_d = 1'b0;
                            acc_hi_d = '0;
                            acc_lo_d = b_mag;
                            opnd_d   = a_mag;
                            a_raw_d  = src_a;
                            neg_q_d  = a_neg ^ b_neg;
                            neg_r_d  = 1'b0;
                            dbz_d    = 1'b0;
                            cnt_d    = '0;
                        end
                        OP_DIV, OP_DIVU: begin
                            state_d  = ST_CALC;
                            is_div_d = 1'b1;
                            acc_hi_d = '0;
                            acc_lo_d = a_mag;
                            opnd_d   = b_mag;
                            a_raw_d  = src_a;
                            neg_q_d  = a_neg ^ b_neg;
                            neg_r_d  = a_neg;
                            dbz_d    = (src_b == '0);
                            cnt_d    = '0;
                        end
                        OP_MTHI: hi_d = src_a;
                        OP_MTLO: lo_d = src_a;
                        default: ;
                    endcase
                end
            end
            ST_CALC: begin
                if (cancel) begin
                    state_d = ST_IDLE;
                end else begin
                    acc_hi_d = step_hi;
                    acc_lo_d = step_lo;
                    cnt_d    = cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (cancel) begin
                    state_d = ST_IDLE;
                end else if (out_ready) begin
                    state_d = ST_IDLE;
                    if (!is_div_q) begin
                        hi_d = prod_fix[2*W-1:W];
                        lo_d = prod_fix[W-1:0];
                    end else if (dbz_q) begin
                        hi_d = a_raw_q;
                        lo_d = '1;
                    end else begin
                        hi_d = rem_fix;
                        lo_d = quo_fix;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            opnd_q   <= '0;
            a_raw_q  <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            neg_q_q  <= 1'b0;
            neg_r_q  <= 1'b0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            opnd_q   <= opnd_d;
            a_raw_q  <= a_raw_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            neg_q_q  <= neg_q_d;
            neg_r_q  <= neg_r_d;
            dbz_q    <= dbz_d;
        end
    end

    assign out_valid   = (state_q == ST_DONE);
    assign div_by_zero = (state_q == ST_DONE) && dbz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule

// File: tb/tb_mycpu_muldiv.sv
// Scoreboard bench for mycpu_muldiv at DATA_WIDTH=32.
// Driver pushes expected results; a monitor pops them on handshake.
module tb_mycpu_muldiv;
    import mycpu_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  op = 3'd0;
    logic [31:0] src_a = '0;
    logic [31:0] src_b = '0;
    logic        cancel = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        div_by_zero;
    logic [31:0] hi, lo;

    mycpu_muldiv #(
        .DATA_WIDTH (32),
        .SIGN_EN    (1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .op          (op),
        .src_a       (src_a),
        .src_b       (src_b),
        .cancel      (cancel),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
        int          acc;
    } sb_t;

    sb_t sb[$];
    int  n_cmp = 0;
    int  n_mis = 0;
    int  cyc = 0;
    bit  ign = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: latency, hold stability, and post-handshake HI/LO.
    bit          pend = 1'b0;
    bit          seen = 1'b0;
    sb_t         pexp;
    logic [31:0] snap_hi, snap_lo;
    logic        snap_dbz;
    always @(negedge clk) begin
        #1;
        if (pend) begin
            chk("result_hi", hi, pexp.hi);
            chk("result_lo", lo, pexp.lo);
            pend = 1'b0;
        end
        if (reset) begin
            seen = 1'b0;
        end else if (out_valid && !ign) begin
            if (sb.size() == 0) begin
                chk("unexpected_out_valid", 1, 0);
            end else begin
                if (!seen) begin
                    seen = 1'b1;
                    chk("latency", cyc - sb[0].acc, 33);
                    snap_hi  = hi;
                    snap_lo  = lo;
                    snap_dbz = div_by_zero;
                end else begin
                    chk("hold_hi", hi, snap_hi);
                    chk("hold_lo", lo, snap_lo);
                    chk("hold_dbz", div_by_zero, snap_dbz);
                end
                if (out_ready && !cancel) begin
                    pexp = sb.pop_front();
                    chk("div_by_zero", div_by_zero, pexp.dbz);
                    pend = 1'b1;
                    seen = 1'b0;
                end
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("idle_timeout", 0, 1);
    endtask

    task automatic issue(input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b, input bit push,
                         input logic [31:0] eh, input logic [31:0] el,
                         input logic ed);
        sb_t e;
        wait_idle();
        in_valid = 1'b1;
        op       = o;
        src_a    = a;
        src_b    = b;
        if (push) begin
            e.hi  = eh;
            e.lo  = el;
            e.dbz = ed;
            e.acc = cyc;
            sb.push_back(e);
        end
        @(negedge clk);
        in_valid = 1'b0;
        op       = 3'd2;
        src_a    = 32'hA5A5_0001;
        src_b    = 32'h0000_0003;
    endtask

    task automatic run(input logic [2:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] eh,
                       input logic [31:0] el, input logic ed);
        issue(o, a, b, 1'b1, eh, el, ed);
        wait_idle();
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) chk("valid_timeout", 0, 1);
    endtask

    logic [31:0] h0, l0;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
        chk("rst_out_valid", out_valid, 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("post_rst_in_ready", in_ready, 1);

        // MTLO then MULTU back-to-back
        issue(OP_MTLO, 32'h1234_5678, 32'h0, 1'b0, '0, '0, 1'b0);
        chk("mtlo_lo", lo, 32'h1234_5678);
        chk("mtlo_no_valid", out_valid, 0);
        run(OP_MULTU, 32'd3, 32'd5, 32'h0, 32'h0000_000F, 1'b0);

        // Directed multiply/divide vectors
        run(OP_MULT, 32'hFFFF_FFFF, 32'd2,
            32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);
        run(OP_MULTU, 32'hFFFF_FFFF, 32'd2,
            32'h0000_0001, 32'hFFFF_FFFE, 1'b0);
        run(OP_DIV, 32'hFFFF_FFF9, 32'd2,
            32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        run(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF,
            32'h0, 32'h8000_0000, 1'b0);
        run(OP_DIVU, 32'd7, 32'd0, 32'd7, 32'hFFFF_FFFF, 1'b1);
        run(OP_DIV, 32'hFFFF_FFFB, 32'd0,
            32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1);
        run(OP_MULT, 32'hFFFF_FFFD, 32'd5,
            32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
        run(OP_DIVU, 32'hFFFF_FFFF, 32'h10,
            32'h0000_000F, 32'h0FFF_FFFF, 1'b0);
        run(OP_DIV, 32'd7, 32'hFFFF_FFFE,
            32'h0000_0001, 32'hFFFF_FFFD, 1'b0);
        run(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
            32'hFFFF_FFFE, 32'h0000_0001, 1'b0);

        // Consumer stalls 3 cycles in DONE
        out_ready = 1'b0;
        issue(OP_DIV, 32'd100, 32'd7, 1'b1, 32'd2, 32'd14, 1'b0);
        wait_valid();
        repeat (3) @(negedge clk);
        out_ready = 1'b1;
        wait_idle();

        // Reserved op is a no-op
        h0 = hi;
        l0 = lo;
        issue(3'd6, 32'h1111_1111, 32'h2222_2222, 1'b0, '0, '0, 1'b0);
        chk("rsv_in_ready", in_ready, 1);
        @(negedge clk);
        chk("rsv_no_valid", out_valid, 0);
        chk("rsv_hi", hi, h0);
        chk("rsv_lo", lo, l0);

        // Cancel in the 5th CALC cycle
        issue(OP_MULTU, 32'd3, 32'd4, 1'b0, '0, '0, 1'b0);
        repeat (4) @(negedge clk);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        #1;
        chk("cancel_idle", in_ready, 1);
        chk("cancel_no_valid", out_valid, 0);
        chk("cancel_hi", hi, h0);
        chk("cancel_lo", lo, l0);
        repeat (40) @(negedge clk);

        // Cancel together with in_valid: not accepted
        cancel   = 1'b1;
        in_valid = 1'b1;
        op       = OP_MTHI;
        src_a    = 32'hDEAD_BEEF;
        #1;
        chk("cancel_blocks_ready", in_ready, 0);
        @(negedge clk);
        cancel   = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("cancel_no_mthi", hi, h0);

        // Cancel in DONE beats out_ready
        ign       = 1'b1;
        out_ready = 1'b0;
        issue(OP_MULTU, 32'd6, 32'd7, 1'b0, '0, '0, 1'b0);
        wait_valid();
        cancel    = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        ign    = 1'b0;
        #1;
        chk("done_cancel_valid", out_valid, 0);
        chk("done_cancel_hi", hi, h0);
        chk("done_cancel_lo", lo, l0);

        // Reset during an operation
        issue(OP_MTHI, 32'hCAFE_F00D, 32'h0, 1'b0, '0, '0, 1'b0);
        chk("mthi_hi", hi, 32'hCAFE_F00D);
        issue(OP_DIVU, 32'd1000, 32'd3, 1'b0, '0, '0, 1'b0);
        repeat (10) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("mid_rst_in_ready", in_ready, 0);
        @(negedge clk);
        chk("mid_rst_hi", hi, 0);
        chk("mid_rst_lo", lo, 0);
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_dbz", div_by_zero, 0);
        reset = 1'b0;
        #1;
        chk("mid_rst_ready_after", in_ready, 1);
        run(OP_MULTU, 32'd9, 32'd9, 32'h0, 32'd81, 1'b0);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_mis);
        $finish;
    end

endmodule
